// File: rtl/table_lookup_t.sv
// AES round T-table lookup for one 32-bit state column: S-box per byte, then {2S,S,S,3S} rotated per lane.
// Optional macro TABLE_LOOKUP_OUTREG_EN adds an output register stage (latency 2 instead of 1).
module table_lookup_t (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] state,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);

  // FIPS-197 forward S-box, index 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime_f(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Lane i holds byte b_i; b0 is the most significant byte of the column.
  logic [3:0][7:0] w_sub;
  logic [3:0][7:0] r_s_p1;
  logic [3:0][7:0] w_d;
  logic [3:0][7:0] w_t;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_sub[gi] = sbox_f(state[8*(3-gi) +: 8]);
    assign w_d[gi]   = xtime_f(r_s_p1[gi]);
    assign w_t[gi]   = w_d[gi] ^ r_s_p1[gi];
  end

  // Stage 1: registered S-box outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_p1 <= '0;
    end else begin
      r_s_p1 <= w_sub;
    end
  end

  logic [31:0] w_p0;
  logic [31:0] w_p1;
  logic [31:0] w_p2;
  logic [31:0] w_p3;

  assign w_p0 = {w_d[0], r_s_p1[0], r_s_p1[0], w_t[0]};
  assign w_p1 = {w_t[1], w_d[1], r_s_p1[1], r_s_p1[1]};
  assign w_p2 = {r_s_p1[2], w_t[2], w_d[2], r_s_p1[2]};
  assign w_p3 = {r_s_p1[3], r_s_p1[3], w_t[3], w_d[3]};

`ifdef TABLE_LOOKUP_OUTREG_EN
  logic [31:0] r_p0_p2;
  logic [31:0] r_p1_p2;
  logic [31:0] r_p2_p2;
  logic [31:0] r_p3_p2;

  // Stage 2: registered T-words to cut the xtime/XOR path from the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0_p2 <= '0;
      r_p1_p2 <= '0;
      r_p2_p2 <= '0;
      r_p3_p2 <= '0;
    end else begin
      r_p0_p2 <= w_p0;
      r_p1_p2 <= w_p1;
      r_p2_p2 <= w_p2;
      r_p3_p2 <= w_p3;
    end
  end

  assign p0 = r_p0_p2;
  assign p1 = r_p1_p2;
  assign p2 = r_p2_p2;
  assign p3 = r_p3_p2;
`else
  assign p0 = w_p0;
  assign p1 = w_p1;
  assign p2 = w_p2;
  assign p3 = w_p3;
`endif

endmodule

// File: tb/tb_table_lookup_t.sv
// Bench for table_lookup_t: directed AES vectors, reset behaviour, streaming and a full per-lane byte sweep.
module tb_table_lookup_t;

`ifdef TABLE_LOOKUP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] state;
  logic [31:0] p0, p1, p2, p3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] m1, m2, m_exp;

  table_lookup_t dut (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .p0    (p0),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // General GF(2^8) multiply, independent of the DUT's xtime shortcut.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      ref_sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] tword(input logic [31:0] st);
    logic [7:0] s [4];
    logic [7:0] d [4];
    logic [7:0] t [4];
    for (int i = 0; i < 4; i++) begin
      s[i] = ref_sbox[st[8*(3-i) +: 8]];
      d[i] = gmul(s[i], 8'h02);
      t[i] = gmul(s[i], 8'h03);
    end
    return {d[0], s[0], s[0], t[0],
            t[1], d[1], s[1], s[1],
            s[2], t[2], d[2], s[2],
            s[3], s[3], t[3], d[3]};
  endfunction

  // One clock: drive on the falling edge, update the cycle model at the rising edge, check 1 ns later.
  task automatic step(input logic [31:0] st, input logic rn, input string tag);
    @(negedge clk);
    state = st;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      m2 = '0;
      m1 = '0;
    end else begin
      m2 = m1;
      m1 = tword(st);
    end
    m_exp = (LAT == 2) ? m2 : m1;
    #1;
    chk({tag, ".p0"}, p0, m_exp[127:96]);
    chk({tag, ".p1"}, p1, m_exp[95:64]);
    chk({tag, ".p2"}, p2, m_exp[63:32]);
    chk({tag, ".p3"}, p3, m_exp[31:0]);
  endtask

  task automatic hold_and_check(input logic [31:0] st, input logic [127:0] hand, input string tag);
    for (int k = 0; k < LAT; k++) step(st, 1'b1, {tag, ".model"});
    chk({tag, ".hand_p0"}, p0, hand[127:96]);
    chk({tag, ".hand_p1"}, p1, hand[95:64]);
    chk({tag, ".hand_p2"}, p2, hand[63:32]);
    chk({tag, ".hand_p3"}, p3, hand[31:0]);
  endtask

  localparam logic [127:0] T_VEC  = 128'hb3d4d467_694e2727_11332211_aeaee947;
  localparam logic [127:0] T_ZERO = 128'hc66363a5_a5c66363_63a5c663_6363a5c6;
  localparam logic [127:0] T_ONES = 128'h2c16163a_3a2c1616_163a2c16_16163a2c;

  logic [31:0]  st_sw;
  logic [127:0] exp_sw;

  initial begin
    rst_n = 1'b0;
    state = 32'h193de3be;
    m1 = '0;
    m2 = '0;
    build_sbox();
    chk("refmodel_vec", tword(32'h193de3be)[127:96], T_VEC[127:96]);

    // Reset held for two edges: outputs forced to zero regardless of input.
    step(32'h193de3be, 1'b0, "reset0");
    step(32'h193de3be, 1'b0, "reset1");
    chk("reset_zero_p0", p0, 32'h0);

    hold_and_check(32'h193de3be, T_VEC,  "vec");
    hold_and_check(32'h00000000, T_ZERO, "zero");
    hold_and_check(32'hffffffff, T_ONES, "ones");

    // Back-to-back stream, no stalls.
    step(32'h193de3be, 1'b1, "stream0");
    step(32'h00000000, 1'b1, "stream1");
    step(32'hffffffff, 1'b1, "stream2");
    step(32'h193de3be, 1'b1, "stream3");
    chk("stream_lat_p0", p0, (LAT == 1) ? T_VEC[127:96] : T_ONES[127:96]);

    // Reset for one edge in the middle of a stream, then resume.
    step(32'h00000000, 1'b1, "mid0");
    step(32'hffffffff, 1'b0, "mid_rst");
    chk("mid_rst_zero_p1", p1, 32'h0);
    step(32'h193de3be, 1'b1, "mid1");
    step(32'h00000000, 1'b1, "mid2");
    step(32'hffffffff, 1'b1, "mid3");
    chk("mid_resume_p3", p3, (LAT == 1) ? T_ONES[31:0] : T_ZERO[31:0]);

    // Every byte value through every lane, streamed.
    for (int i = 0; i < 256; i++) begin
      st_sw = {8'(i), 8'(i) ^ 8'h55, 8'(i) ^ 8'haa, ~8'(i)};
      step(st_sw, 1'b1, $sformatf("sweep%0d", i));
    end
    for (int k = 0; k < LAT; k++) step(32'h0, 1'b1, "sweep_flush");
    exp_sw = T_ZERO;
    chk("sweep_end_p2", p2, exp_sw[63:32]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
